l2_arbiter_rr: RTL and testbench

Parametrised N-requester line-transfer arbiter between the L1 caches (icache, dcache, and any future prefetch or victim-buffer ports) and the next memory level (L2 or physical memory). It generalises the fixed two-port instruction/data arbiter in three ways:
- any number of requesters, each of which may read or write;
- selectable round-robin or fixed-priority grant;
- registered request capture, so the downstream address and write data are held stable for the whole transaction.

Responses and read data are routed back to the granted requester only.

---
 rtl/l2_arbiter_rr_pkg.sv | 20 ++
 rtl/l2_arbiter_rr_picker.sv | 38 +++
 rtl/l2_arbiter_rr.sv | 144 ++++++++++++++
 tb/tb_l2_arbiter_rr.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_arbiter_rr_pkg.sv
// Shared types for the L1-to-next-level line-transfer arbiter.
package l2_arbiter_rr_pkg;

  // Default element types: a 16-bit word address and a 128-bit L1 line.
  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_L1_line;

  // Arbiter FSM state: IDLE arbitrates, BUSY holds one transaction open.
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } lc3b_arb_state_t;

  // Direction of the captured transaction.
  typedef enum logic {
    ARB_OP_READ  = 1'b0,
    ARB_OP_WRITE = 1'b1
  } lc3b_arb_op_t;

endpackage

// File: rtl/l2_arbiter_rr_picker.sv
// Combinational winner selection: round-robin starting at ptr, or
// fixed priority where the lowest active index wins.
module l2_arbiter_rr_picker #(
  parameter int NUM_REQ    = 2,
  parameter int FIXED_PRIO = 0,
  localparam int PTR_W     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] active,
  input  logic [PTR_W-1:0]   ptr,
  output logic [PTR_W-1:0]   g,
  output logic               found
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  // Scan from the lowest priority to the highest so the last hit wins.
  always_comb begin
    g     = '0;
    found = |active;
    sum   = '0;
    idx   = '0;
    if (FIXED_PRIO != 0) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (active[i]) g = PTR_W'(i);
      end
    end else begin
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
        // Explicit modulo so non-power-of-two NUM_REQ wraps to index 0.
        sum = {1'b0, ptr} + (PTR_W + 1)'(off);
        if (sum >= (PTR_W + 1)'(NUM_REQ)) sum = sum - (PTR_W + 1)'(NUM_REQ);
        idx = sum[PTR_W-1:0];
        if (active[idx]) g = idx;
      end
    end
  end

endmodule

// File: rtl/l2_arbiter_rr.sv
// N-requester line-transfer arbiter between the L1 caches and the next
// memory level. One transaction at a time; the winner's address, write line
// and direction are captured at grant and held until mem_resp.
//
// Handshake: a requester raises req_read or req_write and holds it until it
// sees its req_resp bit; the arbiter raises mem_read/mem_write for the whole
// transaction and the transaction ends in the cycle mem_resp is high, which
// is also the cycle req_resp[g] pulses. One idle cycle always follows so the
// finishing requester can drop its request before re-arbitration.
module l2_arbiter_rr
  import l2_arbiter_rr_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = $bits(lc3b_word),
  parameter int LINE_WIDTH = $bits(lc3b_L1_line),
  parameter int FIXED_PRIO = 0,
  localparam int PTR_W     = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_read,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_address,
  input  logic [NUM_REQ*LINE_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_resp,
  output logic [LINE_WIDTH-1:0]         req_rdata,
  output logic                          mem_read,
  output logic                          mem_write,
  output logic [ADDR_WIDTH-1:0]         mem_address,
  output logic [LINE_WIDTH-1:0]         mem_wdata,
  input  logic                          mem_resp,
  input  logic [LINE_WIDTH-1:0]         mem_rdata,
  output lc3b_arb_state_t               dbg_state
);

  lc3b_arb_state_t       state_q, state_d;
  lc3b_arb_op_t          op_q, op_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [PTR_W-1:0]      g_q, g_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;

  logic [NUM_REQ-1:0]    active;
  logic [PTR_W-1:0]      pick_g;
  logic                  pick_found;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [LINE_WIDTH-1:0] sel_wdata;
  logic                  sel_write;

  assign active = req_read | req_write;

  l2_arbiter_rr_picker #(
    .NUM_REQ    (NUM_REQ),
    .FIXED_PRIO (FIXED_PRIO)
  ) u_picker (
    .active (active),
    .ptr    (ptr_q),
    .g      (pick_g),
    .found  (pick_found)
  );

  // Mux the winner's address, write line and direction off the flat buses.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_g == PTR_W'(i)) begin
        sel_addr  = req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[i*LINE_WIDTH +: LINE_WIDTH];
        sel_write = req_write[i];
      end
    end
  end

  // Next-state: grant and capture in IDLE, wait for mem_resp in BUSY.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d = ARB_BUSY;
          g_d     = pick_g;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          // A requester asserting both strobes is treated as a write.
          op_d    = sel_write ? ARB_OP_WRITE : ARB_OP_READ;
          if (FIXED_PRIO == 0) begin
            if (pick_g == PTR_W'(NUM_REQ - 1)) ptr_d = '0;
            else                               ptr_d = pick_g + PTR_W'(1);
          end
        end
      end
      ARB_BUSY: begin
        if (mem_resp) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State and capture registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      op_q    <= ARB_OP_READ;
      ptr_q   <= '0;
      g_q     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Completion routing: only the granted requester sees mem_resp, only in BUSY.
  always_comb begin
    req_resp = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_resp[i] = (state_q == ARB_BUSY) && mem_resp && (g_q == PTR_W'(i));
    end
  end

  assign mem_read    = (state_q == ARB_BUSY) && (op_q == ARB_OP_READ);
  assign mem_write   = (state_q == ARB_BUSY) && (op_q == ARB_OP_WRITE);
  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;
  assign req_rdata   = mem_rdata;
  assign dbg_state   = state_q;

  // Simultaneous read and write from one requester is a protocol error.
  a_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
    (req_read & req_write) == '0);

endmodule

// File: tb/tb_l2_arbiter_rr.sv
// Directed bench for l2_arbiter_rr: one round-robin and one fixed-priority
// instance (both NUM_REQ = 3) share the same stimulus. Expected completions
// are queued by the driver and checked by per-instance monitors.
module tb_l2_arbiter_rr
  import l2_arbiter_rr_pkg::*;
;

  localparam int N  = 3;
  localparam int AW = 16;
  localparam int LW = 128;
  localparam int EW = N + 1 + AW + LW;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT signals ----------------
  logic [N-1:0]    req_read;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_address;
  logic [N*LW-1:0] req_wdata;
  logic            mem_resp;
  logic [LW-1:0]   mem_rdata;

  logic [N-1:0]    rr_resp,   fp_resp;
  logic [LW-1:0]   rr_rdata,  fp_rdata;
  logic            rr_mread,  fp_mread;
  logic            rr_mwrite, fp_mwrite;
  logic [AW-1:0]   rr_maddr,  fp_maddr;
  logic [LW-1:0]   rr_mwdata, fp_mwdata;
  lc3b_arb_state_t rr_state,  fp_state;

  l2_arbiter_rr #(.NUM_REQ(N), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
    .req_address(req_address), .req_wdata(req_wdata), .req_resp(rr_resp),
    .req_rdata(rr_rdata), .mem_read(rr_mread), .mem_write(rr_mwrite),
    .mem_address(rr_maddr), .mem_wdata(rr_mwdata), .mem_resp(mem_resp),
    .mem_rdata(mem_rdata), .dbg_state(rr_state)
  );

  l2_arbiter_rr #(.NUM_REQ(N), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .FIXED_PRIO(1)) u_fp (
    .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
    .req_address(req_address), .req_wdata(req_wdata), .req_resp(fp_resp),
    .req_rdata(fp_rdata), .mem_read(fp_mread), .mem_write(fp_mwrite),
    .mem_address(fp_maddr), .mem_wdata(fp_mwdata), .mem_resp(mem_resp),
    .mem_rdata(mem_rdata), .dbg_state(fp_state)
  );

  // ---------------- scoreboard state ----------------
  int n_total = 0;
  int n_pass  = 0;
  logic [EW-1:0] exp_rr_q[$];
  logic [EW-1:0] exp_fp_q[$];

  logic [AW-1:0] addr_v[N];
  logic [LW-1:0] wd_v[N];

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic load_bus();
    for (int i = 0; i < N; i++) begin
      req_address[i*AW +: AW] = addr_v[i];
      req_wdata[i*LW +: LW]   = wd_v[i];
    end
  endtask

  task automatic set_defaults();
    addr_v[0] = 16'h1230;
    addr_v[1] = 16'h2345;
    addr_v[2] = 16'h3456;
    wd_v[0]   = 128'h00112233445566778899AABBCCDDEEFF;
    wd_v[1]   = 128'hDEAD0123456789ABCDEF01234567BEEF;
    wd_v[2]   = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    load_bus();
  endtask

  function automatic logic [EW-1:0] mk(input int g, input logic op);
    logic [N-1:0] oh;
    oh = '0;
    oh[g] = 1'b1;
    return {oh, op, addr_v[g], wd_v[g]};
  endfunction

  task automatic push_exp(input int g_rr, input int g_fp, input logic op);
    exp_rr_q.push_back(mk(g_rr, op));
    exp_fp_q.push_back(mk(g_fp, op));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rr_strobes"}, {30'b0, rr_mread, rr_mwrite}, 32'h0);
    chk({tag, "_fp_strobes"}, {30'b0, fp_mread, fp_mwrite}, 32'h0);
    chk({tag, "_rr_state"}, {31'b0, rr_state}, {31'b0, ARB_IDLE});
    chk({tag, "_fp_state"}, {31'b0, fp_state}, {31'b0, ARB_IDLE});
  endtask

  // Called in the cycle the request is visible (cycle 0). mem_resp is driven
  // in cycle 1+lat; on return the bench sits in the dead cycle after it.
  task automatic transact(input int lat, input logic [LW-1:0] rd, input logic op,
                          input logic [N-1:0] drop, input logic scramble);
    tick();
    if (scramble) begin
      for (int i = 0; i < N; i++) begin
        addr_v[i] = ~addr_v[i];
        wd_v[i]   = ~wd_v[i];
      end
      load_bus();
    end
    @(negedge clk);
    chk("grant_rr_strobes", {30'b0, rr_mread, rr_mwrite}, {30'b0, ~op, op});
    chk("grant_fp_strobes", {30'b0, fp_mread, fp_mwrite}, {30'b0, ~op, op});
    for (int c = 2; c <= lat + 1; c++) begin
      tick();
      if (c == lat + 1) begin
        mem_resp  = 1'b1;
        mem_rdata = rd;
      end
      @(negedge clk);
      chk("busy_rr_strobes", {30'b0, rr_mread, rr_mwrite}, {30'b0, ~op, op});
    end
    tick();
    mem_resp  = 1'b0;
    req_read  = req_read & ~drop;
    req_write = req_write & ~drop;
    @(negedge clk);
    chk_idle_outputs("dead");
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin : mon_rr
    logic [EW-1:0] e;
    if (rr_resp !== '0) begin
      n_total++;
      if (exp_rr_q.size() == 0) begin
        $display("FAIL rr_resp_unexpected: got resp %b expected none", rr_resp);
      end else begin
        e = exp_rr_q.pop_front();
        if ({rr_resp, rr_mwrite, rr_maddr, rr_mwdata} === e) n_pass++;
        else $display("FAIL rr_txn: got %h expected %h", {rr_resp, rr_mwrite, rr_maddr, rr_mwdata}, e);
      end
      n_total++;
      if (rr_rdata === mem_rdata) n_pass++;
      else $display("FAIL rr_rdata: got %h expected %h", rr_rdata, mem_rdata);
    end
  end

  always @(negedge clk) begin : mon_fp
    logic [EW-1:0] e;
    if (fp_resp !== '0) begin
      n_total++;
      if (exp_fp_q.size() == 0) begin
        $display("FAIL fp_resp_unexpected: got resp %b expected none", fp_resp);
      end else begin
        e = exp_fp_q.pop_front();
        if ({fp_resp, fp_mwrite, fp_maddr, fp_mwdata} === e) n_pass++;
        else $display("FAIL fp_txn: got %h expected %h", {fp_resp, fp_mwrite, fp_maddr, fp_mwdata}, e);
      end
      n_total++;
      if (fp_rdata === mem_rdata) n_pass++;
      else $display("FAIL fp_rdata: got %h expected %h", fp_rdata, mem_rdata);
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int rr_seq3[5];
    int rr_seq4[4];
    rr_seq3 = '{0, 1, 2, 0, 1};
    rr_seq4 = '{1, 2, 1, 2};

    rst       = 1'b1;
    req_read  = '0;
    req_write = '0;
    mem_resp  = 1'b0;
    mem_rdata = '0;
    set_defaults();
    do_reset();

    // Reset values and idle behaviour.
    @(negedge clk);
    chk_idle_outputs("reset");
    chk("reset_rr_addr", {16'b0, rr_maddr}, 32'h0);
    chk("reset_rr_wdata_zero", {31'b0, |rr_mwdata}, 32'h0);
    tick();
    mem_resp = 1'b1;
    @(negedge clk);
    chk("idle_resp_rr", {29'b0, rr_resp}, 32'h0);
    chk("idle_resp_fp", {29'b0, fp_resp}, 32'h0);
    tick();
    mem_resp = 1'b0;

    // Single read from requester 0, mem_resp three cycles after the strobe.
    req_read = 3'b001;
    push_exp(0, 0, 1'b0);
    transact(3, 128'hCAFEF00D_11112222_33334444_55556666, 1'b0, 3'b001, 1'b0);

    // All three requesters continuously active.
    do_reset();
    req_read = 3'b111;
    for (int t = 0; t < 5; t++) begin
      push_exp(rr_seq3[t], 0, 1'b0);
      transact(1 + (t % 2), {4{32'hA5000000 + t}}, 1'b0, (t == 4) ? 3'b111 : 3'b000, 1'b0);
    end

    // Requesters 1 and 2 both active: fixed priority starves 2.
    do_reset();
    req_read = 3'b110;
    for (int t = 0; t < 4; t++) begin
      push_exp(rr_seq4[t], 1, 1'b0);
      transact(1, {4{32'h5A000000 + t}}, 1'b0, (t == 3) ? 3'b110 : 3'b000, 1'b0);
    end

    // Write from requester 1; bus contents change after the grant.
    req_write = 3'b010;
    push_exp(1, 1, 1'b1);
    transact(2, '0, 1'b1, 3'b010, 1'b1);
    set_defaults();

    // Reset in the middle of a write from requester 2.
    req_write = 3'b100;
    tick();
    @(negedge clk);
    chk("midrst_rr_write_on", {31'b0, rr_mwrite}, 32'h1);
    chk("midrst_fp_write_on", {31'b0, fp_mwrite}, 32'h1);
    tick();
    rst       = 1'b1;
    req_write = '0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk_idle_outputs("midrst");
    chk("midrst_rr_addr", {16'b0, rr_maddr}, 32'h0);
    chk("midrst_fp_wdata_zero", {31'b0, |fp_mwdata}, 32'h0);
    tick();
    mem_resp = 1'b1;
    @(negedge clk);
    chk("late_resp_rr", {29'b0, rr_resp}, 32'h0);
    chk("late_resp_fp", {29'b0, fp_resp}, 32'h0);
    tick();
    mem_resp = 1'b0;
    repeat (3) tick();

    // Every queued completion must have been observed.
    chk("rr_queue_drained", exp_rr_q.size(), 32'h0);
    chk("fp_queue_drained", exp_fp_q.size(), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
